// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_pkg: shared helpers for the FIFO read-side word unpacker.       |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package fifo_pkg;

  // Widest FIFO word the slice helper can handle.
  localparam int SLICE_MAX_BITS = 256;

  typedef logic [SLICE_MAX_BITS-1:0] wide_word_t;

  // Slices per word, or 0 when the width pair is illegal.
  function automatic int ratio(input int in_bits, input int out_bits);
    if (in_bits <= 0 || out_bits <= 0 || in_bits > SLICE_MAX_BITS) return 0;
    if ((in_bits % out_bits) != 0) return 0;
    return in_bits / out_bits;
  endfunction

  function automatic wide_word_t slice_sel(input wide_word_t word, input int idx,
                                           input logic msb_first, input int out_bits,
                                           input int n_slices);
    int         sel;
    wide_word_t mask;
    sel  = msb_first ? (n_slices - 1 - idx) : idx;
    mask = '1;
    mask = ~(mask << out_bits);
    return (word >> (sel * out_bits)) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_unpacker_word_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_word_buf: two-entry flop FIFO with a combinational head.        |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module fifo_word_buf #(
  parameter int WIDTH = 32
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // entry0 is always the head; a pop shifts entry1 forward.
  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (do_pop) begin
      entry0_d = entry1_q;
      count_d  = count_q - 2'd1;
    end
    if (do_push) begin
      if (count_d == 2'd0) begin
        entry0_d = push_data;
      end else begin
        entry1_d = push_data;
      end
      count_d = count_d + 2'd1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign head  = entry0_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_unpacker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_rd_unpacker: pops FIFO words and streams them as slices.        |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module fifo_rd_unpacker
  import fifo_pkg::*;
#(
  parameter int IN_BITS   = 32,
  parameter int OUT_BITS  = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  output logic                fifo_rd_en,
  input  logic [IN_BITS-1:0]  fifo_rd_data,
  input  logic                fifo_rd_empty,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [OUT_BITS-1:0] m_data,
  output logic                m_last,
  output logic [1:0]          word_count
);

  localparam int RATIO  = ratio(IN_BITS, OUT_BITS);
  localparam int SIDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if (RATIO == 0) begin : g_bad_ratio
      $error("fifo_rd_unpacker: IN_BITS must be a non-zero multiple of OUT_BITS");
    end
  endgenerate

  logic               inflight_q, inflight_d;
  logic [SIDX_W-1:0]  slice_idx_q, slice_idx_d;
  logic [IN_BITS-1:0] head_word;
  logic [1:0]         buf_count;
  logic               handshake;
  logic               word_done;
  logic               last_slice;
  logic [2:0]         owned;
  wide_word_t         head_wide;
  wide_word_t         slice_wide;

  fifo_word_buf #(
    .WIDTH (IN_BITS)
  ) u_word_buf (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .push      (inflight_q),
    .push_data (fifo_rd_data),
    .pop       (word_done),
    .head      (head_word),
    .count     (buf_count)
  );

  generate
    if (RATIO <= 1) begin : g_single_slice
      assign last_slice = 1'b1;
    end else begin : g_multi_slice
      assign last_slice = (slice_idx_q == SIDX_W'(RATIO - 1));
    end
  endgenerate

  assign m_valid    = (buf_count != 2'd0);
  assign m_last     = m_valid & last_slice;
  assign handshake  = m_valid & m_ready;
  assign word_done  = handshake & m_last;
  assign word_count = buf_count;

  // Credit: a word retiring this cycle frees its slot for a pop in the same cycle.
  assign owned      = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, word_done};
  assign fifo_rd_en = !rd_rst && !fifo_rd_empty && (owned < 3'd2);

  always_comb begin
    inflight_d  = fifo_rd_en;
    slice_idx_d = slice_idx_q;
    if (handshake) begin
      slice_idx_d = m_last ? '0 : slice_idx_q + SIDX_W'(1);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      inflight_q  <= 1'b0;
      slice_idx_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      slice_idx_q <= slice_idx_d;
    end
  end

  assign head_wide = wide_word_t'(head_word);

  always_comb begin
    slice_wide = slice_sel(head_wide, int'(slice_idx_q), MSB_FIRST, OUT_BITS, RATIO);
    m_data     = m_valid ? OUT_BITS'(slice_wide) : '0;
  end

  a_no_pop_when_empty: assert property (@(posedge rd_clk)
    !(fifo_rd_en && fifo_rd_empty));

  a_owned_max_two: assert property (@(posedge rd_clk) disable iff (rd_rst)
    (({1'b0, buf_count} + {2'b00, inflight_q}) <= 3'd2));

  a_hold_under_backpressure: assert property (@(posedge rd_clk) disable iff (rd_rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));

endmodule
`default_nettype wire
